// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the alarm-clock key front end
//
// Purpose : channel FSM state type, key index constants, default timing
//           constants and a constant max helper used for counter sizing.
// Ports   : none (package).
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   localparam int KEY_SET   = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_ALARM = 3;
   localparam int KEY_MODE  = 4;

   localparam int DEF_NUM_KEYS        = 5;
   localparam int DEF_CLK_HZ          = 100_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
   localparam int DEF_LONG_CYCLES     = 100_000_000;
   localparam int DEF_REPEAT_CYCLES   = 20_000_000;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// rtl/key_event_ctrl_if.sv - key pins in, debounced key events out
//
// Purpose : bundles the raw key lines and the event outputs of key_event_ctrl.
// Signals : key         raw button levels, 1 = pressed
//           key_level   debounced key state
//           key_press   one-cycle pulse on accepted press
//           key_release one-cycle pulse on accepted release
//           key_long    one-cycle long-press (and auto-repeat) pulse
//           key_any     OR of key_press
// Modports: master - board/pin side (drives key, observes events)
//           slave  - key_event_ctrl side
interface key_event_ctrl_if #(
   parameter int NUM_KEYS = clock_pkg::DEF_NUM_KEYS
);
   logic [NUM_KEYS-1:0] key;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic [NUM_KEYS-1:0] key_long;
   logic                key_any;

   modport master (
      output key,
      input  key_level, key_press, key_release, key_long, key_any
   );

   modport slave (
      input  key,
      output key_level, key_press, key_release, key_long, key_any
   );
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-flop synchroniser, debounce FSM, hold/repeat counters
//
// Purpose : turns one raw button line into level/press/release/long events.
//           Optional auto-repeat of key_long is built only with KEY_AUTOREPEAT_EN.
// Ports   : clk, rst      clock, synchronous active-high reset
//           key_i         raw asynchronous key level
//           level_o       debounced level
//           press_o       press pulse
//           release_o     release pulse
//           long_o        long-press / repeat pulse
module key_debounce_ch
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);
   localparam int CW = $clog2(max_i(DEBOUNCE_CYCLES, LONG_CYCLES)) + 1;
   // The sample that leaves IDLE/HELD counts as the first stable sample,
   // so the wait states finish after DEBOUNCE_CYCLES samples in total.
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

   logic [1:0]    sync_q;
   key_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] hold_q, hold_d;
   logic          long_d;
   logic          s;
   logic          held_smp;

   assign s = sync_q[1];
   // A pressed sample while the key is accepted as down; the sample that
   // resumes HELD from RELEASE_WAIT counts as hold time too.
   assign held_smp = s && ((state_q == HELD) || (state_q == RELEASE_WAIT));

`ifdef KEY_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_q, rep_d;
`endif

   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (held_smp) begin
         if (hold_q != LONG_SAT) hold_d = hold_q + 1'b1;
         if (hold_q == LONG_LAST) long_d = 1'b1;
      end
`ifdef KEY_AUTOREPEAT_EN
      rep_d = rep_q;
      if (held_smp && (hold_q == LONG_SAT)) begin
         if (state_q == RELEASE_WAIT) begin
            rep_d = '0;
         end else if (rep_q == REP_LAST) begin
            rep_d  = '0;
            long_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         level_o   <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         long_o    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rep_q     <= '0;
`endif
      end else begin
         sync_q    <= {sync_q[0], key_i};
         press_o   <= 1'b0;
         release_o <= 1'b0;
         long_o    <= long_d;
         hold_q    <= hold_d;
`ifdef KEY_AUTOREPEAT_EN
         rep_q     <= rep_d;
`endif
         case (state_q)
            IDLE: begin
               if (s) begin
                  cnt_q   <= '0;
                  state_q <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_q <= IDLE;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= HELD;
                  level_o <= 1'b1;
                  press_o <= 1'b1;
                  cnt_q   <= '0;
                  hold_q  <= '0;
`ifdef KEY_AUTOREPEAT_EN
                  rep_q   <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  cnt_q   <= '0;
                  state_q <= RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_q <= HELD;
               end else if (cnt_q == DEB_LAST) begin
                  state_q   <= IDLE;
                  level_o   <= 1'b0;
                  release_o <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - five-key debounce and event generator for the alarm clock
//
// Purpose : NUM_KEYS independent key_debounce_ch channels plus key_any.
//           Build option: KEY_AUTOREPEAT_EN adds key_long auto-repeat.
// Ports   : clk  system clock
//           rst  synchronous active-high reset
//           bus  key_event_ctrl_if.slave (key in; key_level, key_press,
//                key_release, key_long, key_any out)
module key_event_ctrl
   import clock_pkg::*;
#(
   parameter int NUM_KEYS        = DEF_NUM_KEYS,
   parameter int CLK_HZ          = DEF_CLK_HZ,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   key_event_ctrl_if.slave   bus
);
   logic [NUM_KEYS-1:0] level_w, press_w, release_w, long_w;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .key_i     (bus.key[k]),
         .level_o   (level_w[k]),
         .press_o   (press_w[k]),
         .release_o (release_w[k]),
         .long_o    (long_w[k])
      );
   end

   assign bus.key_level   = level_w;
   assign bus.key_press   = press_w;
   assign bus.key_release = release_w;
   assign bus.key_long    = long_w;
   assign bus.key_any     = |press_w;
endmodule
